// File: rtl/thumb_pkg.sv
// Shared types for the Thumb decode stage: command codes, prefix test and bundle payload.
package thumb_pkg;

  typedef enum logic [6:0] {
    CMD_LSL_IMM  = 7'd0,
    CMD_LSR_IMM  = 7'd1,
    CMD_ASR_IMM  = 7'd2,
    CMD_ADD_REG  = 7'd3,
    CMD_SUB_REG  = 7'd4,
    CMD_ADD_IMM3 = 7'd5,
    CMD_SUB_IMM3 = 7'd6,
    CMD_MOV_IMM  = 7'd7,
    CMD_CMP_IMM  = 7'd8,
    CMD_ADD_IMM8 = 7'd9,
    CMD_SUB_IMM8 = 7'd10,
    CMD_UNDEF16  = 7'd126,
    CMD_T32      = 7'd127
  } cmd_e;

  // Width-independent part of a decoded bundle; register and immediate fields are
  // parameterised at the top level and travel alongside.
  typedef struct packed {
    cmd_e        cmd;
    logic        is32;
    logic [31:0] raw;
    logic [31:0] pc;
  } dec_bundle_t;

  // First halfword of a 32-bit encoding: hw[15:11] is 11101, 11110 or 11111.
  function automatic logic is_t32_prefix(input logic [15:0] hw);
    return (hw[15:13] == 3'b111) && (hw[12:11] != 2'b00);
  endfunction

endpackage

// File: rtl/thumb16_field_decode.sv
// Combinational field extraction for the 16-bit shift/add/sub/move/compare group.
module thumb16_field_decode
  import thumb_pkg::*;
#(
  parameter int unsigned REG_W = 4,
  parameter int unsigned IMM_W = 32
) (
  input  logic [15:0]      hw,
  output cmd_e             cmd_c,
  output logic [REG_W-1:0] rm_c,
  output logic [REG_W-1:0] rn_c,
  output logic [REG_W-1:0] rd_c,
  output logic [IMM_W-1:0] imm_c
);

  // Decode by hw[13:11], then hw[10:9] inside the register/imm3 add/sub subgroup.
  always_comb begin
    cmd_c = CMD_UNDEF16;
    rm_c  = '0;
    rn_c  = '0;
    rd_c  = '0;
    imm_c = '0;
    if (hw[15:14] == 2'b00) begin
      case (hw[13:11])
        3'b000, 3'b001, 3'b010: begin
          case (hw[12:11])
            2'b00:   cmd_c = CMD_LSL_IMM;
            2'b01:   cmd_c = CMD_LSR_IMM;
            default: cmd_c = CMD_ASR_IMM;
          endcase
          imm_c = IMM_W'(hw[10:6]);
          rm_c  = REG_W'(hw[5:3]);
          rd_c  = REG_W'(hw[2:0]);
        end
        3'b011: begin
          case (hw[10:9])
            2'b00:   cmd_c = CMD_ADD_REG;
            2'b01:   cmd_c = CMD_SUB_REG;
            2'b10:   cmd_c = CMD_ADD_IMM3;
            default: cmd_c = CMD_SUB_IMM3;
          endcase
          // hw[10] selects whether [8:6] is a register or a 3-bit immediate
          if (hw[10]) imm_c = IMM_W'(hw[8:6]);
          else        rm_c  = REG_W'(hw[8:6]);
          rn_c = REG_W'(hw[5:3]);
          rd_c = REG_W'(hw[2:0]);
        end
        3'b100: begin
          cmd_c = CMD_MOV_IMM;
          rd_c  = REG_W'(hw[10:8]);
          imm_c = IMM_W'(hw[7:0]);
        end
        3'b101: begin
          cmd_c = CMD_CMP_IMM;
          rn_c  = REG_W'(hw[10:8]);
          imm_c = IMM_W'(hw[7:0]);
        end
        default: begin
          cmd_c = hw[11] ? CMD_SUB_IMM8 : CMD_ADD_IMM8;
          rd_c  = REG_W'(hw[10:8]);
          rn_c  = REG_W'(hw[10:8]);
          imm_c = IMM_W'(hw[7:0]);
        end
      endcase
    end
  end

endmodule

// File: rtl/thumb_decode_stage.sv
// Registered Thumb decode stage: halfword queue, 32-bit pairing, PC tracking, output bundle.
module thumb_decode_stage
  import thumb_pkg::*;
#(
  parameter int unsigned HW_DEPTH = 4,
  parameter int unsigned IMM_W    = 32,
  parameter int unsigned REG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hw_valid,
  input  logic [15:0]      hw_data,
  output logic             hw_ready,
  input  logic             flush,
  input  logic [31:0]      flush_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output cmd_e             dec_cmd,
  output logic             dec_is32,
  output logic [31:0]      dec_raw,
  output logic [REG_W-1:0] dec_rm,
  output logic [REG_W-1:0] dec_rn,
  output logic [REG_W-1:0] dec_rd,
  output logic [IMM_W-1:0] dec_imm,
  output logic [31:0]      dec_pc
);

  localparam int unsigned     PTR_W    = (HW_DEPTH > 1) ? $clog2(HW_DEPTH) : 1;
  localparam int unsigned     CNT_W    = $clog2(HW_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(HW_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HW_DEPTH);

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [15:0]      q_mem [HW_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc;

  logic [PTR_W-1:0] head_nxt1_c;
  logic [PTR_W-1:0] head_next_c;
  logic [15:0]      hw0_c;
  logic [15:0]      hw1_c;
  logic             head_is32_c;
  logic             head_complete_c;
  logic             push_c;
  logic             load_c;
  logic [CNT_W-1:0] pop_n_c;
  logic [CNT_W-1:0] count_next_c;
  dec_bundle_t      nxt_c;

  cmd_e             f_cmd_c;
  logic [REG_W-1:0] f_rm_c;
  logic [REG_W-1:0] f_rn_c;
  logic [REG_W-1:0] f_rd_c;
  logic [IMM_W-1:0] f_imm_c;

  thumb16_field_decode #(
    .REG_W (REG_W),
    .IMM_W (IMM_W)
  ) u_field_decode (
    .hw    (hw0_c),
    .cmd_c (f_cmd_c),
    .rm_c  (f_rm_c),
    .rn_c  (f_rn_c),
    .rd_c  (f_rd_c),
    .imm_c (f_imm_c)
  );

  // Head inspection, pairing, push/pop arbitration and next bundle assembly.
  always_comb begin
    head_nxt1_c     = ptr_inc(head);
    hw0_c           = q_mem[head];
    hw1_c           = q_mem[head_nxt1_c];
    head_is32_c     = is_t32_prefix(hw0_c);
    head_complete_c = (count >= CNT_W'(2)) || ((count == CNT_W'(1)) && !head_is32_c);
    push_c          = hw_valid && hw_ready && !flush;
    load_c          = !flush && head_complete_c && (!dec_valid || dec_ready);
    pop_n_c         = '0;
    head_next_c     = head;
    if (load_c) begin
      if (head_is32_c) begin
        pop_n_c     = CNT_W'(2);
        head_next_c = ptr_inc(head_nxt1_c);
      end else begin
        pop_n_c     = CNT_W'(1);
        head_next_c = head_nxt1_c;
      end
    end
    count_next_c = count + CNT_W'(push_c) - pop_n_c;

    nxt_c      = '0;
    nxt_c.is32 = head_is32_c;
    nxt_c.cmd  = head_is32_c ? CMD_T32 : f_cmd_c;
    nxt_c.raw  = head_is32_c ? {hw0_c, hw1_c} : {16'h0000, hw0_c};
    nxt_c.pc   = pc;
  end

  // Halfword storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) q_mem[tail] <= hw_data;
  end

  // Queue pointers, occupancy, acceptance flag and PC of the head halfword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      hw_ready <= 1'b1;
      pc       <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      hw_ready <= 1'b1;
      pc       <= flush_pc & 32'hFFFF_FFFE;
    end else begin
      head     <= head_next_c;
      if (push_c) tail <= ptr_inc(tail);
      count    <= count_next_c;
      hw_ready <= (count_next_c < CNT_FULL);
      if (load_c) pc <= pc + (head_is32_c ? 32'd4 : 32'd2);
    end
  end

  // Output bundle register: loads on a free or draining slot, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      dec_cmd   <= CMD_LSL_IMM;
      dec_is32  <= 1'b0;
      dec_raw   <= '0;
      dec_rm    <= '0;
      dec_rn    <= '0;
      dec_rd    <= '0;
      dec_imm   <= '0;
      dec_pc    <= '0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (load_c) begin
      dec_valid <= 1'b1;
      dec_cmd   <= nxt_c.cmd;
      dec_is32  <= nxt_c.is32;
      dec_raw   <= nxt_c.raw;
      dec_pc    <= nxt_c.pc;
      dec_rm    <= head_is32_c ? '0 : f_rm_c;
      dec_rn    <= head_is32_c ? '0 : f_rn_c;
      dec_rd    <= head_is32_c ? '0 : f_rd_c;
      dec_imm   <= head_is32_c ? '0 : f_imm_c;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_thumb_decode_stage.sv
// Bench for thumb_decode_stage: directed corner sequences, decode table, random stream vs model.
module tb_thumb_decode_stage;
  import thumb_pkg::*;

  localparam int unsigned HW_DEPTH = 4;
  localparam int unsigned IMM_W    = 32;
  localparam int unsigned REG_W    = 4;

  logic             clk;
  logic             rst_n;
  logic             hw_valid;
  logic [15:0]      hw_data;
  logic             hw_ready;
  logic             flush;
  logic [31:0]      flush_pc;
  logic             dec_valid;
  logic             dec_ready;
  cmd_e             dec_cmd;
  logic             dec_is32;
  logic [31:0]      dec_raw;
  logic [REG_W-1:0] dec_rm;
  logic [REG_W-1:0] dec_rn;
  logic [REG_W-1:0] dec_rd;
  logic [IMM_W-1:0] dec_imm;
  logic [31:0]      dec_pc;

  thumb_decode_stage #(
    .HW_DEPTH (HW_DEPTH),
    .IMM_W    (IMM_W),
    .REG_W    (REG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hw_valid  (hw_valid),
    .hw_data   (hw_data),
    .hw_ready  (hw_ready),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_cmd   (dec_cmd),
    .dec_is32  (dec_is32),
    .dec_raw   (dec_raw),
    .dec_rm    (dec_rm),
    .dec_rn    (dec_rn),
    .dec_rd    (dec_rd),
    .dec_imm   (dec_imm),
    .dec_pc    (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]       cmd;
    logic             is32;
    logic [31:0]      raw;
    logic [REG_W-1:0] rm;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic [31:0]      pc;
  } bundle_t;

  typedef struct {
    logic [15:0]      hw;
    logic [6:0]       cmd;
    logic [REG_W-1:0] rm;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } vec_t;

  bundle_t     exp_q[$];
  logic        pend_v;
  logic [15:0] pend_hw;
  logic [31:0] m_pc;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] fld(input logic is32, input logic [REG_W-1:0] rm,
                                      input logic [REG_W-1:0] rn, input logic [REG_W-1:0] rd,
                                      input logic [IMM_W-1:0] imm);
    return 64'({is32, rm, rn, rd, imm});
  endfunction

  function automatic logic [63:0] dut_fld();
    return fld(dec_is32, dec_rm, dec_rn, dec_rd, dec_imm);
  endfunction

  // Reference decode by numeric ranges of the halfword and div/mod field extraction.
  function automatic bundle_t ref16(input logic [15:0] hw, input logic [31:0] pc);
    bundle_t     e;
    int unsigned v, k;
    v     = 32'(hw);
    e.cmd = 7'd126; e.is32 = 1'b0; e.raw = {16'h0000, hw};
    e.rm = '0; e.rn = '0; e.rd = '0; e.imm = '0; e.pc = pc;
    if (v < 32'h1800) begin
      e.cmd = 7'(v / 32'h800);
      e.imm = IMM_W'((v / 64) % 32); e.rm = REG_W'((v / 8) % 8); e.rd = REG_W'(v % 8);
    end else if (v < 32'h1C00) begin
      e.cmd = (v < 32'h1A00) ? 7'd3 : 7'd4;
      e.rm = REG_W'((v / 64) % 8); e.rn = REG_W'((v / 8) % 8); e.rd = REG_W'(v % 8);
    end else if (v < 32'h2000) begin
      e.cmd = (v < 32'h1E00) ? 7'd5 : 7'd6;
      e.imm = IMM_W'((v / 64) % 8); e.rn = REG_W'((v / 8) % 8); e.rd = REG_W'(v % 8);
    end else if (v < 32'h4000) begin
      k     = (v - 32'h2000) / 32'h800;
      e.cmd = 7'(7 + k);
      e.imm = IMM_W'(v % 256);
      if (k != 1) e.rd = REG_W'((v / 256) % 8);
      if (k != 0) e.rn = REG_W'((v / 256) % 8);
    end
    return e;
  endfunction

  task automatic model_reset(input logic [31:0] pc);
    exp_q.delete();
    pend_v = 1'b0;
    pend_hw = '0;
    m_pc = pc;
  endtask

  task automatic model_push(input logic [15:0] hw);
    bundle_t e;
    if (pend_v) begin
      e.cmd = 7'd127; e.is32 = 1'b1; e.raw = {pend_hw, hw};
      e.rm = '0; e.rn = '0; e.rd = '0; e.imm = '0; e.pc = m_pc;
      exp_q.push_back(e);
      m_pc   = m_pc + 32'd4;
      pend_v = 1'b0;
    end else if (hw >= 16'hE800) begin
      pend_v  = 1'b1;
      pend_hw = hw;
    end else begin
      exp_q.push_back(ref16(hw, m_pc));
      m_pc = m_pc + 32'd2;
    end
  endtask

  task automatic chk_bundle(input bundle_t e);
    chk("stream_cmd", 64'(dec_cmd), 64'(e.cmd));
    chk("stream_raw", 64'(dec_raw), 64'(e.raw));
    chk("stream_pc", 64'(dec_pc), 64'(e.pc));
    chk("stream_fields", dut_fld(), fld(e.is32, e.rm, e.rn, e.rd, e.imm));
  endtask

  // One clock: check outputs and handshakes at the negedge, update the model, return #1 after posedge.
  task automatic step();
    int occ;
    @(negedge clk);
    occ = pend_v ? 1 : 0;
    foreach (exp_q[i]) occ += exp_q[i].is32 ? 2 : 1;
    if (dec_valid && exp_q.size() > 0) occ -= exp_q[0].is32 ? 2 : 1;
    chk("hw_ready", 64'(hw_ready), 64'(occ < int'(HW_DEPTH)));
    if (dec_valid) begin
      if (exp_q.size() == 0) chk("spurious_bundle", 64'(dec_valid), 64'(0));
      else chk_bundle(exp_q[0]);
    end
    if (flush) begin
      model_reset(flush_pc & 32'hFFFF_FFFE);
    end else begin
      if (dec_valid && dec_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (hw_valid && hw_ready) model_push(hw_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h07FF, CMD_LSL_IMM,  4'd7, 4'd0, 4'd7, 32'd31};
    tbl[1]  = '{16'h0A4B, CMD_LSR_IMM,  4'd1, 4'd0, 4'd3, 32'd9};
    tbl[2]  = '{16'h1111, CMD_ASR_IMM,  4'd2, 4'd0, 4'd1, 32'd4};
    tbl[3]  = '{16'h1A53, CMD_SUB_REG,  4'd1, 4'd2, 4'd3, 32'd0};
    tbl[4]  = '{16'h1C48, CMD_ADD_IMM3, 4'd0, 4'd1, 4'd0, 32'd1};
    tbl[5]  = '{16'h1E9D, CMD_SUB_IMM3, 4'd0, 4'd3, 4'd5, 32'd2};
    tbl[6]  = '{16'h2000, CMD_MOV_IMM,  4'd0, 4'd0, 4'd0, 32'd0};
    tbl[7]  = '{16'h2FFF, CMD_CMP_IMM,  4'd0, 4'd7, 4'd0, 32'd255};
    tbl[8]  = '{16'h3642, CMD_ADD_IMM8, 4'd0, 4'd6, 4'd6, 32'h42};
    tbl[9]  = '{16'h3901, CMD_SUB_IMM8, 4'd0, 4'd1, 4'd1, 32'd1};
    tbl[10] = '{16'hE7FF, CMD_UNDEF16,  4'd0, 4'd0, 4'd0, 32'd0};
    tbl[11] = '{16'h8123, CMD_UNDEF16,  4'd0, 4'd0, 4'd0, 32'd0};

    rst_n = 1'b1; hw_valid = 1'b0; hw_data = '0; flush = 1'b0; flush_pc = '0; dec_ready = 1'b1;
    model_reset(32'h0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dec_valid", 64'(dec_valid), 64'(0));
    chk("reset_hw_ready", 64'(hw_ready), 64'(1));
    chk("reset_cmd", 64'(dec_cmd), 64'(0));
    chk("reset_raw", 64'(dec_raw), 64'(0));
    chk("reset_pc", 64'(dec_pc), 64'(0));
    chk("reset_fields", dut_fld(), 64'(0));
    rst_n = 1'b1;

    // First instruction latency and ADD_reg decode
    hw_valid = 1'b1; hw_data = 16'h1888; step();
    hw_valid = 1'b0;
    chk("t1_latency", 64'(dec_valid), 64'(0));
    step();
    chk("t1_valid", 64'(dec_valid), 64'(1));
    chk("t1_cmd", 64'(dec_cmd), 64'(CMD_ADD_REG));
    chk("t1_fields", dut_fld(), fld(1'b0, 4'd2, 4'd1, 4'd0, 32'd0));
    chk("t1_pc", 64'(dec_pc), 64'(32'h0));

    // MOV_imm then CMP_imm back to back
    hw_valid = 1'b1; hw_data = 16'h235A; step();
    hw_data = 16'h2B10; step();
    hw_valid = 1'b0;
    chk("t2_mov_cmd", 64'(dec_cmd), 64'(CMD_MOV_IMM));
    chk("t2_mov_fields", dut_fld(), fld(1'b0, 4'd0, 4'd0, 4'd3, 32'h5A));
    chk("t2_mov_pc", 64'(dec_pc), 64'(32'h2));
    step();
    chk("t2_cmp_cmd", 64'(dec_cmd), 64'(CMD_CMP_IMM));
    chk("t2_cmp_fields", dut_fld(), fld(1'b0, 4'd0, 4'd3, 4'd0, 32'h10));
    chk("t2_cmp_pc", 64'(dec_pc), 64'(32'h4));

    // Lone prefix waits, then pairs into a 32-bit bundle
    hw_valid = 1'b1; hw_data = 16'hF000; step();
    hw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_prefix_wait", 64'(dec_valid), 64'(0));
    end
    hw_valid = 1'b1; hw_data = 16'hF800; step();
    hw_valid = 1'b0;
    chk("t3_pair_latency", 64'(dec_valid), 64'(0));
    step();
    chk("t3_valid", 64'(dec_valid), 64'(1));
    chk("t3_cmd", 64'(dec_cmd), 64'(CMD_T32));
    chk("t3_raw", 64'(dec_raw), 64'(32'hF000F800));
    chk("t3_fields", dut_fld(), fld(1'b1, 4'd0, 4'd0, 4'd0, 32'd0));
    chk("t3_pc", 64'(dec_pc), 64'(32'h6));
    hw_valid = 1'b1; hw_data = 16'h1888; step();
    hw_valid = 1'b0; step();
    chk("t3_next_pc", 64'(dec_pc), 64'(32'hA));

    // Backpressure: fill the queue, hold outputs, then stream out one per cycle
    step();
    chk("t4_idle", 64'(dec_valid), 64'(0));
    dec_ready = 1'b0; hw_valid = 1'b1; hw_data = 16'h1C48;
    repeat (6) step();
    chk("t4_full", 64'(hw_ready), 64'(0));
    chk("t4_hold_valid", 64'(dec_valid), 64'(1));
    chk("t4_hold_pc", 64'(dec_pc), 64'(32'hC));
    repeat (2) step();
    chk("t4_hold_pc2", 64'(dec_pc), 64'(32'hC));
    chk("t4_hold_raw", 64'(dec_raw), 64'(32'h1C48));
    dec_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 2) hw_valid = 1'b0;
      chk("t4_stream_valid", 64'(dec_valid), 64'(1));
      chk("t4_stream_pc", 64'(dec_pc), 64'(32'(12 + 2 * k)));
    end
    step();
    chk("t4_drained", 64'(dec_valid), 64'(0));

    // Flush drops the queued prefix and the halfword offered alongside it
    hw_valid = 1'b1; hw_data = 16'hF000; step();
    flush = 1'b1; flush_pc = 32'h101; hw_data = 16'h235A; step();
    flush = 1'b0; hw_valid = 1'b0;
    chk("t5_flush_ready", 64'(hw_ready), 64'(1));
    chk("t5_flush_valid", 64'(dec_valid), 64'(0));
    hw_valid = 1'b1; hw_data = 16'h1888; step();
    hw_valid = 1'b0; step();
    chk("t5_cmd", 64'(dec_cmd), 64'(CMD_ADD_REG));
    chk("t5_pc", 64'(dec_pc), 64'(32'h100));

    // Undefined 16-bit encoding, then asynchronous reset mid-stream
    hw_valid = 1'b1; hw_data = 16'h4000; step();
    hw_valid = 1'b0; step();
    chk("t6_undef_cmd", 64'(dec_cmd), 64'(CMD_UNDEF16));
    chk("t6_undef_fields", dut_fld(), 64'(0));
    chk("t6_undef_raw", 64'(dec_raw), 64'(32'h4000));
    chk("t6_undef_pc", 64'(dec_pc), 64'(32'h102));
    hw_valid = 1'b1; hw_data = 16'hF000; step();
    hw_data = 16'h1888; step();
    hw_data = 16'h2000;
    #2 rst_n = 1'b0;
    model_reset(32'h0);
    #1;
    chk("t6_rst_valid", 64'(dec_valid), 64'(0));
    chk("t6_rst_ready", 64'(hw_ready), 64'(1));
    chk("t6_rst_pc", 64'(dec_pc), 64'(0));
    hw_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    hw_valid = 1'b1; hw_data = 16'h1888; step();
    hw_valid = 1'b0; step();
    chk("t6_after_cmd", 64'(dec_cmd), 64'(CMD_ADD_REG));
    chk("t6_after_pc", 64'(dec_pc), 64'(0));

    // Decode table
    for (int i = 0; i < 12; i++) begin
      hw_valid = 1'b1; hw_data = tbl[i].hw; step();
      hw_valid = 1'b0; step();
      chk("tbl_valid", 64'(dec_valid), 64'(1));
      chk("tbl_cmd", 64'(dec_cmd), 64'(tbl[i].cmd));
      chk("tbl_fields", dut_fld(), fld(1'b0, tbl[i].rm, tbl[i].rn, tbl[i].rd, tbl[i].imm));
      chk("tbl_raw", 64'(dec_raw), 64'({16'h0000, tbl[i].hw}));
    end

    // Random stream with backpressure and occasional flush, checked by the model in step()
    for (int c = 0; c < 400; c++) begin
      int sel;
      sel       = int'($urandom_range(0, 9));
      hw_valid  = ($urandom_range(0, 9) < 7);
      hw_data   = (sel < 6) ? 16'($urandom_range(0, 32'h3FFF)) :
                  (sel < 8) ? 16'($urandom_range(32'hE800, 32'hFFFF)) : 16'($urandom());
      dec_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) == 0);
      flush_pc  = $urandom();
      step();
    end
    flush = 1'b0; hw_valid = 1'b0; dec_ready = 1'b1;
    repeat (12) step();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
